// File: rtl/key_step_controller.sv
// Push-button front end for the up/down LED counter: sync, debounce, one enable step per press.
// Auto-repeat on a held key (DELAY/REPEAT states and timer) is built only with KEY_STEP_AUTO_REPEAT_EN.
module key_step_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    output logic       up_down,
    output logic       enable,
    output logic       lock,
    output logic [1:0] state_dbg
);
    localparam int            DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    state_t state, state_n;

    // Index 0 is the up key, index 1 the down key; raw and debounced levels are active-low.
    logic [1:0]    sync1, sync2, db, db_prev, armed;
    logic [1:0]    held, press;
    logic [1:0]    warm_sr;
    logic [DW-1:0] cnt [2];
    logic          enable_n, up_down_n;
    logic          held_active, held_other;

`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            TW         = $clog2(RMAX + 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
    logic [TW-1:0] timer, timer_n;
`endif

    // A key is armed only after it has been seen released with a settled synchroniser, so a
    // key held through reset debounces to pressed without producing a press edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            db      <= 2'b11;
            db_prev <= 2'b11;
            armed   <= 2'b00;
            warm_sr <= 2'b00;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1   <= {key_dn_n, key_up_n};
            sync2   <= sync1;
            db_prev <= db;
            warm_sr <= {warm_sr[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_MAX) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                if (warm_sr[1] && sync2[i] && db[i]) armed[i] <= 1'b1;
            end
        end
    end

    assign held  = ~db;
    assign press = db_prev & ~db & armed;

    // The last step direction doubles as the identity of the key currently being held.
    assign held_active = up_down ? held[0] : held[1];
    assign held_other  = up_down ? held[1] : held[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            enable  <= 1'b0;
            up_down <= 1'b1;
        end else begin
            state   <= state_n;
            enable  <= enable_n;
            up_down <= up_down_n;
        end
    end

`ifdef KEY_STEP_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timer <= '0;
        else        timer <= timer_n;
    end
`endif

    always_comb begin
        state_n   = state;
        enable_n  = 1'b0;
        up_down_n = up_down;
`ifdef KEY_STEP_AUTO_REPEAT_EN
        timer_n   = '0;
`endif
        case (state)
            IDLE: begin
                if ((press[0] && held[1]) || (press[1] && held[0])) begin
                    state_n = LOCK;
                end else if (press[0] || press[1]) begin
                    enable_n  = 1'b1;
                    up_down_n = press[0];
                    state_n   = DELAY;
                end
            end
            DELAY: begin
                if (held_other)        state_n = LOCK;
                else if (!held_active) state_n = IDLE;
`ifdef KEY_STEP_AUTO_REPEAT_EN
                else if (timer == DELAY_LAST) begin
                    enable_n = 1'b1;
                    state_n  = REPEAT;
                end else begin
                    timer_n = timer + 1'b1;
                end
`endif
            end
`ifdef KEY_STEP_AUTO_REPEAT_EN
            REPEAT: begin
                if (held_other)               state_n  = LOCK;
                else if (!held_active)        state_n  = IDLE;
                else if (timer == RATE_LAST)  enable_n = 1'b1;
                else                          timer_n  = timer + 1'b1;
            end
`endif
            LOCK: begin
                if (held == 2'b00) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign lock      = (held == 2'b11) || (state == LOCK);
    assign state_dbg = state;

endmodule

// File: tb/tb_key_step_controller.sv
// Directed plus random bench for key_step_controller against a time-stamp based reference model.
module tb_key_step_controller;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;
`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_HELD = 1;
    localparam int M_LOCK = 2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic       up_down, enable, lock;
    logic [1:0] state_dbg;

    int   n_checks = 0;
    int   n_err    = 0;
    logic prev_en  = 1'b0;

    key_step_controller #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_up_n  (key_up_n),
        .key_dn_n  (key_dn_n),
        .up_down   (up_down),
        .enable    (enable),
        .lock      (lock),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Debounced level flips once the last DB+1 synchronised samples all disagree with it;
    // steps are scheduled from the time stamp of the first step of a press.
    bit   raw_h  [2][2];
    bit   win    [2][DB+1];
    int   win_n  [2];
    bit   m_db   [2];
    bit   m_dbp  [2];
    bit   m_arm  [2];
    int   m_e, m_t0, m_mode;
    bit   m_dir;
    logic exp_en, exp_ud, exp_lock;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            raw_h[i][0] = 1'b1;
            raw_h[i][1] = 1'b1;
            win_n[i]    = 0;
            m_db[i]     = 1'b1;
            m_dbp[i]    = 1'b1;
            m_arm[i]    = 1'b0;
            for (int j = 0; j <= DB; j++) win[i][j] = 1'b0;
        end
        m_e = 0; m_t0 = 0; m_mode = M_IDLE; m_dir = 1'b1;
        exp_en = 1'b0; exp_ud = 1'b1; exp_lock = 1'b0;
    endtask

    task automatic model_edge(input bit ku, input bit kd);
        bit raw [2];
        bit smp [2];
        bit nd  [2];
        bit narm [2];
        bit held [2];
        bit press [2];
        bit flip;
        int a, o, since;
        raw[0] = ku;
        raw[1] = kd;
        m_e++;
        for (int i = 0; i < 2; i++) begin
            smp[i]      = raw_h[i][1];
            raw_h[i][1] = raw_h[i][0];
            raw_h[i][0] = raw[i];
            for (int j = DB; j > 0; j--) win[i][j] = win[i][j-1];
            win[i][0] = smp[i];
            if (win_n[i] < DB + 1) win_n[i]++;
            flip = (win_n[i] == DB + 1);
            for (int j = 0; j <= DB; j++) if (win[i][j] == m_db[i]) flip = 1'b0;
            nd[i]    = flip ? ~m_db[i] : m_db[i];
            narm[i]  = m_arm[i] | (m_e >= 3 && smp[i] && m_db[i]);
            held[i]  = !m_db[i];
            press[i] = m_dbp[i] && !m_db[i] && m_arm[i];
        end
        exp_en = 1'b0;
        a = m_dir ? 0 : 1;
        o = 1 - a;
        case (m_mode)
            M_IDLE: begin
                if ((press[0] && held[1]) || (press[1] && held[0])) m_mode = M_LOCK;
                else if (press[0] || press[1]) begin
                    m_dir = press[0]; exp_en = 1'b1; m_t0 = m_e; m_mode = M_HELD;
                end
            end
            M_HELD: begin
                since = m_e - m_t0;
                if (held[o])       m_mode = M_IDLE + M_LOCK;
                else if (!held[a]) m_mode = M_IDLE;
                else if (AUTO && since >= RD && (since - RD) % RR == 0) exp_en = 1'b1;
            end
            default: begin
                if (!held[0] && !held[1]) m_mode = M_IDLE;
            end
        endcase
        m_dbp  = m_db;
        m_db   = nd;
        m_arm  = narm;
        exp_ud = m_dir;
        exp_lock = (!m_db[0] && !m_db[1]) || (m_mode == M_LOCK);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_edge(key_up_n, key_dn_n);
    end

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("enable", enable, exp_en);
            check("up_down", up_down, exp_ud);
            check("lock", lock, exp_lock);
            if (enable === 1'b1) check("enable_gap", prev_en, 1'b0);
            prev_en = enable;
        end
    endtask

    task automatic run_count(input int n, output int pulses, output int first, output logic ud);
        pulses = 0;
        first  = -1;
        ud     = 1'bx;
        for (int c = 1; c <= n; c++) begin
            cyc(1);
            if (enable === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    ud    = up_down;
                end
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int   p, f, tot;
        logic ud;

        reset = 1'b0;
        cyc(3);
        check("rst_enable", enable, 1'b0);
        check("rst_up_down", up_down, 1'b1);
        check("rst_lock", lock, 1'b0);
        reset = 1'b1;
        cyc(6);

        key_up_n = 1'b0;
        run_count(100, p, f, ud);
        check_int("up_latency", f - 1, DB + 3);
        check("up_dir", ud, 1'b1);
        check_int("up_hold_pulses", p, AUTO ? 11 : 1);
        key_up_n = 1'b1;
        run_count(20, p, f, ud);
        check_int("up_release_pulses", p, 0);

        tot = 0;
        for (int i = 0; i < 10; i++) begin
            key_dn_n = (i % 2 == 1);
            run_count(3, p, f, ud);
            tot += p;
        end
        check_int("bounce_pulses", tot, 0);
        key_dn_n = 1'b0;
        run_count(30, p, f, ud);
        check_int("dn_latency", f - 1, DB + 3);
        check("dn_dir", ud, 1'b0);
        check_int("dn_hold_pulses", p, AUTO ? 2 : 1);
        key_dn_n = 1'b1;
        cyc(12);

        key_up_n = 1'b0;
        run_count(10, p, f, ud);
        check_int("lock_first_step", p, 1);
        key_dn_n = 1'b0;
        run_count(20, p, f, ud);
        check_int("lock_no_step", p, 0);
        check("lock_both", lock, 1'b1);
        key_dn_n = 1'b1;
        run_count(15, p, f, ud);
        check_int("lock_dn_release_pulses", p, 0);
        check("lock_held", lock, 1'b1);
        key_up_n = 1'b1;
        run_count(15, p, f, ud);
        check_int("lock_exit_pulses", p, 0);
        check("lock_cleared", lock, 1'b0);
        key_dn_n = 1'b0;
        run_count(12, p, f, ud);
        check_int("fresh_dn_latency", f - 1, DB + 3);
        check("fresh_dn_dir", ud, 1'b0);
        key_dn_n = 1'b1;
        cyc(12);

        key_up_n = 1'b0;
        cyc(40);
        reset = 1'b0;
        cyc(2);
        check("midrst_enable", enable, 1'b0);
        check("midrst_up_down", up_down, 1'b1);
        check("midrst_lock", lock, 1'b0);
        reset = 1'b1;
        run_count(40, p, f, ud);
        check_int("held_through_reset_pulses", p, 0);
        key_up_n = 1'b1;
        cyc(12);
        key_up_n = 1'b0;
        run_count(12, p, f, ud);
        check_int("repress_latency", f - 1, DB + 3);
        check("repress_dir", ud, 1'b1);
        key_up_n = 1'b1;
        cyc(12);

        for (int r = 0; r < 120; r++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                cyc($urandom_range(1, 2));
                reset = 1'b1;
            end
            key_up_n = 1'($urandom_range(0, 1));
            key_dn_n = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 40));
        end
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        cyc(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
